// File: rtl/mem_wrapper_pkg.sv
// ---------------------------------------------------------------------------
// mem_wrapper_pkg
// Shared definitions for the memory wrapper access path:
//   - arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT / RESP)
//   - MW_NBW_OP   : default operation code width
//   - OP_*        : operation codes shared with the channel controllers
// ---------------------------------------------------------------------------
package mem_wrapper_pkg;

  localparam int MW_NBW_OP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [MW_NBW_OP-1:0] OP_NOP   = 4'h0;
  localparam logic [MW_NBW_OP-1:0] OP_READ  = 4'h1;
  localparam logic [MW_NBW_OP-1:0] OP_WRITE = 4'h2;
  localparam logic [MW_NBW_OP-1:0] OP_ERASE = 4'h3;

endpackage

// File: rtl/mem_wrapper_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_wrapper_rr_arbiter
// Combinational round-robin picker. The search starts at last_grant+1
// (mod N_CH) and returns the first requesting channel found.
// Ports:
//   req        in  N_CH   request vector
//   last_grant in  IDX_W  index of the previously granted channel
//   grant      out N_CH   one-hot winner (0 when no request)
//   grant_idx  out IDX_W  index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module mem_wrapper_rr_arbiter #(
  parameter int N_CH  = 2,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found_s;
  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Rotating priority search; the first hit after last_grant wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand_s     = (int'(last_grant) + k) % N_CH;
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && req[cand_idx_s]) begin
        found_s           = 1'b1;
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_wrapper_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_wrapper_access_arbiter
// Shares one memory wrapper port among N_CH requesting channels. A request is
// granted round-robin, registered and issued with a one-cycle strobe; the
// grant is held until the memory answers, and the answer is routed back only
// to the granted channel as a one-cycle pulse.
//
// Optional feature macro: MEM_WRAPPER_ARB_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT_CYCLES cycles and answers the
//               granted channel with o_ch_err set and zero data.
//   undefined : WAIT waits indefinitely, o_ch_err is tied to 0.
//
// Ports (channel c occupies slice [c*W +: W] of each packed bus):
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_ch_addr/data/op  per-channel request fields
//   i_ch_region        per-channel region (0 main array, 1 info block)
//   i_ch_op_valid      per-channel level request, held until response
//   o_ch_valid         one-cycle response pulse to the granted channel
//   o_ch_data          response data, 0 on non-granted slices
//   o_ch_err           timeout flag, qualified by o_ch_valid
//   o_grant            one-hot current grant, 0 in IDLE
//   o_busy             high whenever the FSM is not in IDLE
//   o_addr/data/op/region  registered request towards memory
//   o_op_valid         one-cycle issue strobe
//   i_valid, i_data    memory response
// ---------------------------------------------------------------------------
module mem_wrapper_access_arbiter
  import mem_wrapper_pkg::*;
#(
  parameter int NBW_DATA       = 8,
  parameter int NBW_OP         = MW_NBW_OP,
  parameter int N_CH           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_CH*NBW_DATA-1:0] i_ch_addr,
  input  logic [N_CH*NBW_DATA-1:0] i_ch_data,
  input  logic [N_CH*NBW_OP-1:0]   i_ch_op,
  input  logic [N_CH-1:0]          i_ch_region,
  input  logic [N_CH-1:0]          i_ch_op_valid,
  output logic [N_CH-1:0]          o_ch_valid,
  output logic [N_CH*NBW_DATA-1:0] o_ch_data,
  output logic [N_CH-1:0]          o_ch_err,
  output logic [N_CH-1:0]          o_grant,
  output logic                     o_busy,
  output logic [NBW_DATA-1:0]      o_addr,
  output logic [NBW_DATA-1:0]      o_data,
  output logic [NBW_OP-1:0]        o_op,
  output logic                     o_region,
  output logic                     o_op_valid,
  input  logic                     i_valid,
  input  logic [NBW_DATA-1:0]      i_data
);

  localparam int IDX_W = $clog2(N_CH);

  // Elaboration-time sanity checks on the configuration.
  if (N_CH < 2) begin : g_bad_nch
    $error("mem_wrapper_access_arbiter: N_CH must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("mem_wrapper_access_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e                state_r;
  logic [IDX_W-1:0]          last_grant_r;
  logic [N_CH-1:0]           pick_grant_s;
  logic [IDX_W-1:0]          pick_idx_s;
  logic [NBW_DATA-1:0]       sel_addr_s;
  logic [NBW_DATA-1:0]       sel_data_s;
  logic [NBW_OP-1:0]         sel_op_s;
  logic                      sel_region_s;
  logic [N_CH*NBW_DATA-1:0]  resp_data_s;

`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`else
  assign o_ch_err = '0;
`endif

  mem_wrapper_rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (i_ch_op_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .grant_idx  (pick_idx_s)
  );

  // One-hot mux of the winner's request fields (constant slices only).
  always_comb begin
    sel_addr_s   = '0;
    sel_data_s   = '0;
    sel_op_s     = '0;
    sel_region_s = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (pick_grant_s[c]) begin
        sel_addr_s   = i_ch_addr[c*NBW_DATA +: NBW_DATA];
        sel_data_s   = i_ch_data[c*NBW_DATA +: NBW_DATA];
        sel_op_s     = i_ch_op[c*NBW_OP +: NBW_OP];
        sel_region_s = i_ch_region[c];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Response data lands only in the granted channel's slice.
  always_comb begin
    resp_data_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (o_grant[c]) begin
        resp_data_s[c*NBW_DATA +: NBW_DATA] = i_data;
      end else begin
        resp_data_s[c*NBW_DATA +: NBW_DATA] = '0;
      end
    end
  end

  // Arbiter FSM; every output is registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDX_W'(N_CH - 1);
      o_grant      <= '0;
      o_busy       <= 1'b0;
      o_addr       <= '0;
      o_data       <= '0;
      o_op         <= '0;
      o_region     <= 1'b0;
      o_op_valid   <= 1'b0;
      o_ch_valid   <= '0;
      o_ch_data    <= '0;
`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
      o_ch_err     <= '0;
      tmo_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|i_ch_op_valid) begin
            o_addr       <= sel_addr_s;
            o_data       <= sel_data_s;
            o_op         <= sel_op_s;
            o_region     <= sel_region_s;
            o_grant      <= pick_grant_s;
            last_grant_r <= pick_idx_s;
            o_op_valid   <= 1'b1;
            o_busy       <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          o_op_valid <= 1'b0;
`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
          tmo_cnt_r  <= '0;
`endif
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_valid) begin
            o_ch_valid <= o_grant;
            o_ch_data  <= resp_data_s;
            state_r    <= ST_RESP;
          end
`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Last allowed WAIT cycle passed without an answer.
            o_ch_valid <= o_grant;
            o_ch_err   <= o_grant;
            o_ch_data  <= '0;
            state_r    <= ST_RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
`else
          else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          // Always pass through IDLE so the finished channel can drop its request.
          o_ch_valid <= '0;
          o_ch_data  <= '0;
`ifdef MEM_WRAPPER_ARB_TIMEOUT_EN
          o_ch_err   <= '0;
`endif
          o_grant    <= '0;
          o_busy     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          o_ch_valid <= '0;
          o_ch_data  <= '0;
          o_grant    <= '0;
          o_busy     <= 1'b0;
          o_op_valid <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
